// File: rtl/bram_stream_fifo_ctrl.sv
// Streaming FIFO controller around an external 1W/1R block RAM with a 2-entry prefetch buffer.
// Optional synchronous flush port enabled by defining BRAM_STREAM_FIFO_FLUSH_EN.
`timescale 1ns/1ps
module bram_stream_fifo_ctrl #(
   parameter int DATA_WIDTH = 4096,
   parameter int DEPTH      = 64,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef BRAM_STREAM_FIFO_FLUSH_EN
   input  logic                  flush,
`endif
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  ram_we,
   output logic [AW-1:0]         ram_waddr,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic [AW-1:0]         ram_raddr,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic [AW+1:0]         count
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           ram_cnt_q, ram_cnt_d;
   logic                  inflight_q, inflight_d;
   logic [1:0]            obuf_cnt_q, obuf_cnt_d;
   logic                  head_q, head_d;
   logic                  tail_q, tail_d;
   logic                  s_ready_q, s_ready_d;
   logic [AW+1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] obuf_q [2];

   logic                  flush_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  rd_en_s;
   logic                  m_valid_s;
   logic [2:0]            occ_s;

`ifdef BRAM_STREAM_FIFO_FLUSH_EN
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   // Handshakes, read-issue decision and next-state computation
   always_comb begin
      m_valid_s  = (obuf_cnt_q != 2'd0) & ~flush_s;
      push_s     = s_valid & s_ready_q & ~flush_s;
      pop_s      = m_valid_s & m_ready;
      // Occupancy of the output side after this cycle's pop; a read may issue if a slot remains.
      occ_s      = {1'b0, obuf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
      rd_en_s    = (ram_cnt_q != '0) && (occ_s <= 3'd1);

      wr_ptr_d   = push_s  ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = rd_en_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
      ram_cnt_d  = ram_cnt_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, rd_en_s};
      inflight_d = rd_en_s;
      obuf_cnt_d = obuf_cnt_q + {1'b0, inflight_q} - {1'b0, pop_s};
      head_d     = pop_s      ? ~head_q : head_q;
      tail_d     = inflight_q ? ~tail_q : tail_q;

      if (flush_s) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         ram_cnt_d  = '0;
         inflight_d = 1'b0;
         obuf_cnt_d = 2'd0;
         head_d     = 1'b0;
         tail_d     = 1'b0;
      end else begin
         head_d     = head_d;
      end

      s_ready_d  = (ram_cnt_d < DEPTH_C);
      count_d    = {1'b0, ram_cnt_d} + {{(AW+1){1'b0}}, inflight_d} + {{AW{1'b0}}, obuf_cnt_d};
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_cnt_q  <= '0;
         inflight_q <= 1'b0;
         obuf_cnt_q <= 2'd0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         s_ready_q  <= 1'b0;
         count_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ram_cnt_q  <= ram_cnt_d;
         inflight_q <= inflight_d;
         obuf_cnt_q <= obuf_cnt_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         s_ready_q  <= s_ready_d;
         count_q    <= count_d;
      end
   end

   // Output buffer data; validity is carried by obuf_cnt_q, so no reset is needed here
   always_ff @(posedge clk) begin
      if (inflight_q) begin
         obuf_q[tail_q] <= ram_dout;
      end else begin
         obuf_q[tail_q] <= obuf_q[tail_q];
      end
   end

   assign s_ready   = s_ready_q & ~flush_s;
   assign m_valid   = m_valid_s;
   assign m_data    = obuf_q[head_q];
   assign ram_we    = push_s;
   assign ram_waddr = wr_ptr_q;
   assign ram_din   = s_data;
   assign ram_raddr = rd_ptr_q;
   assign count     = count_q;

endmodule

// File: tb/tb_bram_stream_fifo_ctrl.sv
// Self-checking bench: queue-based FIFO model plus a behavioural 1W/1R read-old-data RAM.
`timescale 1ns/1ps
module tb_bram_stream_fifo_ctrl;
   localparam int DW    = 32;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
`ifdef BRAM_STREAM_FIFO_FLUSH_EN
   logic          flush = 1'b0;
`endif
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_din;
   logic [AW-1:0] ram_raddr;
   logic [DW-1:0] ram_dout;
   logic [AW+1:0] count;

   int            checks = 0;
   int            failures = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] mem [DEPTH];

   bram_stream_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef BRAM_STREAM_FIFO_FLUSH_EN
      .flush(flush),
`endif
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
      .ram_raddr(ram_raddr), .ram_dout(ram_dout), .count(count)
   );

   always #5 clk = ~clk;

   // Behavioural block RAM: registered read returning old data on collision
   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_din;
      ram_dout <= mem[ram_raddr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
      checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      rst_n = 1'b1;
      tick();
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_release_s_ready got=%b exp=1", s_ready); end
      q.delete();
   endtask

   // Push one word into an empty controller and verify the 3-cycle latency
   task automatic test_single(input logic [DW-1:0] w, input string tag);
      m_ready = 1'b1;
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL %s_ready got=%b exp=1", tag, s_ready); end
      s_valid = 1'b1; s_data = w;
      tick();
      s_valid = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         checks++; if (m_valid !== 1'b0 || count !== 8'd1) begin
            failures++; $display("FAIL %s_wait%0d m_valid=%b count=%0d exp m_valid=0 count=1", tag, c, m_valid, count);
         end
         tick();
      end
      checks++; if (m_valid !== 1'b1 || m_data !== w || count !== 8'd1) begin
         failures++; $display("FAIL %s_out m_valid=%b m_data=%h count=%0d exp 1 %h 1", tag, m_valid, m_data, count, w);
      end
      tick();
      checks++; if (m_valid !== 1'b0 || count !== '0) begin
         failures++; $display("FAIL %s_drained m_valid=%b count=%0d exp 0 0", tag, m_valid, count);
      end
      m_ready = 1'b0;
   endtask

   task automatic test_fill();
      int n = 0;
      m_ready = 1'b0;
      for (int c = 0; c < 100 && s_ready; c++) begin
         s_valid = 1'b1; s_data = DW'(n);
         tick();
         n++;
      end
      s_valid = 1'b0;
      checks++; if (n != DEPTH + 2) begin failures++; $display("FAIL fill_accepted got=%0d exp=%0d", n, DEPTH + 2); end
      checks++; if (count !== 8'(DEPTH + 2)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count, DEPTH + 2); end
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL fill_s_ready got=%b exp=0", s_ready); end
      m_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) begin
         checks++; if (m_valid !== 1'b1 || m_data !== DW'(i)) begin
            failures++; $display("FAIL fill_drain_%0d m_valid=%b m_data=%h exp 1 %h", i, m_valid, m_data, DW'(i));
         end
         tick();
         if (i == 0) begin
            checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_return got=%b exp=1", s_ready); end
         end
      end
      checks++; if (count !== '0 || m_valid !== 1'b0) begin
         failures++; $display("FAIL fill_empty count=%0d m_valid=%b exp 0 0", count, m_valid);
      end
      m_ready = 1'b0;
   endtask

   task automatic test_stream();
      int sent = 0, rcvd = 0, first = -1, last = -1;
      logic [DW-1:0] exp;
      m_ready = 1'b1;
      for (int c = 0; c < 400 && rcvd < 200; c++) begin
         s_valid = (sent < 200); s_data = DW'(32'h1000 + sent);
         if (m_valid && m_ready) begin
            if (first < 0) begin
               first = c;
               checks++; if (c != 3) begin failures++; $display("FAIL stream_latency got=%0d exp=3", c); end
            end else begin
               checks++; if (c != last + 1) begin failures++; $display("FAIL stream_bubble cycle=%0d prev=%0d", c, last); end
            end
            last = c;
            if (q.size() == 0) begin
               failures++; checks++; $display("FAIL stream_spurious m_data=%h exp none", m_data);
            end else begin
               exp = q.pop_front();
               checks++; if (m_data !== exp) begin failures++; $display("FAIL stream_data got=%h exp=%h", m_data, exp); end
            end
            rcvd++;
         end
         if (s_valid && s_ready) begin q.push_back(s_data); sent++; end
         tick();
      end
      s_valid = 1'b0; m_ready = 1'b0;
      checks++; if (rcvd != 200) begin failures++; $display("FAIL stream_timeout got=%0d exp=200", rcvd); end
   endtask

   task automatic test_random();
      int sent = 0, rcvd = 0, c = 0;
      logic [DW-1:0] exp;
      while (rcvd < 1000 && c < 20000) begin
         s_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
         s_data  = $urandom;
         m_ready = ($urandom_range(0, 1) == 1);
         if (m_valid && m_ready) begin
            if (q.size() == 0) begin
               failures++; checks++; $display("FAIL rand_spurious m_data=%h exp none", m_data);
            end else begin
               exp = q.pop_front();
               checks++; if (m_data !== exp) begin failures++; $display("FAIL rand_data got=%h exp=%h", m_data, exp); end
            end
            rcvd++;
         end
         if (s_valid && s_ready) begin q.push_back(s_data); sent++; end
         tick();
         c++;
         checks++; if (int'(count) != q.size() || int'(count) > DEPTH + 2) begin
            failures++; $display("FAIL rand_count got=%0d exp=%0d", count, q.size());
         end
      end
      s_valid = 1'b0; m_ready = 1'b0;
      checks++; if (rcvd != 1000) begin failures++; $display("FAIL rand_timeout got=%0d exp=1000", rcvd); end
   endtask

   task automatic test_midreset();
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1; s_data = DW'(i);
         tick();
      end
      s_valid = 1'b0;
      tick(); tick();
      // One push and one pop together leaves count at 10 with a read in flight
      s_valid = 1'b1; s_data = DW'(10); m_ready = 1'b1;
      checks++; if (m_valid !== 1'b1 || m_data !== DW'(0)) begin
         failures++; $display("FAIL midrst_head m_valid=%b m_data=%h exp 1 0", m_valid, m_data);
      end
      tick();
      s_valid = 1'b0; m_ready = 1'b0;
      checks++; if (count !== 8'd10) begin failures++; $display("FAIL midrst_pre_count got=%0d exp=10", count); end
      rst_n = 1'b0;
      #1;
      checks++; if (m_valid !== 1'b0 || count !== '0) begin
         failures++; $display("FAIL midrst_async m_valid=%b count=%0d exp 0 0", m_valid, count);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      q.delete();
      test_single(DW'(1), "midrst_after");
   endtask

`ifdef BRAM_STREAM_FIFO_FLUSH_EN
   task automatic test_flush();
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1; s_data = DW'(i + 32'h50);
         tick();
      end
      s_valid = 1'b0;
      tick(); tick();
      checks++; if (count !== 8'd5) begin failures++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
      flush = 1'b1; s_valid = 1'b1; s_data = DW'(32'hDEAD);
      #1;
      checks++; if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
         failures++; $display("FAIL flush_gate s_ready=%b m_valid=%b exp 0 0", s_ready, m_valid);
      end
      tick();
      flush = 1'b0; s_valid = 1'b0;
      checks++; if (count !== '0 || m_valid !== 1'b0) begin
         failures++; $display("FAIL flush_clear count=%0d m_valid=%b exp 0 0", count, m_valid);
      end
      q.delete();
      test_single(DW'(32'h77), "flush_after");
   endtask
`endif

   initial begin
      test_reset();
      test_single(DW'(32'hA5), "single");
      test_fill();
      test_stream();
      test_random();
      test_midreset();
`ifdef BRAM_STREAM_FIFO_FLUSH_EN
      test_flush();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
